// File: rtl/yutorina_gpr_mp_pkg.sv
// Shared configuration for the multi-port general-purpose register file.
package yutorina_gpr_mp_pkg;

   // Default geometry
   localparam int unsigned GPR_DATA_WIDTH = 32;
   localparam int unsigned GPR_ADDR_WIDTH = 5;
   localparam int unsigned GPR_NUM_REGS   = 2 ** GPR_ADDR_WIDTH;
   localparam int unsigned GPR_READ_PORTS = 2;

   // Hard-wired zero register
   localparam int unsigned GPR_ZERO_REG = 0;

   // Active-low strobe levels
   localparam logic STROBE_ENABLE  = 1'b0;
   localparam logic STROBE_DISABLE = 1'b1;

   // Reset is asynchronous and active-low
   localparam logic RESET_ACTIVE = 1'b0;

   // True when an active-low strobe is asserted
   function automatic logic strobe_on(input logic strobe_n);
      return strobe_n == STROBE_ENABLE;
   endfunction

endpackage

// File: rtl/yutorina_gpr_scoreboard.sv
// Pending-result scoreboard: one bit per register set on reserve, cleared on
// writeback or flush, with a registered population count.
module yutorina_gpr_scoreboard
   import yutorina_gpr_mp_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = GPR_ADDR_WIDTH,
   parameter int unsigned READ_PORTS = GPR_READ_PORTS
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             wr0_valid,
   input  logic [ADDR_WIDTH-1:0]            wr0_address,
   input  logic                             wr1_valid,
   input  logic [ADDR_WIDTH-1:0]            wr1_address,
   input  logic                             rsv_valid,
   input  logic [ADDR_WIDTH-1:0]            rsv_address,
   input  logic                             flush,
   input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_address,
   output logic [READ_PORTS-1:0]            read_pending,
   output logic [ADDR_WIDTH:0]              pending_count
);

   localparam int unsigned NUM_REGS  = 2 ** ADDR_WIDTH;
   localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

   logic [NUM_REGS-1:0]  pending_q;
   logic [NUM_REGS-1:0]  pending_d;
   logic [CNT_WIDTH-1:0] count_q;
   logic [CNT_WIDTH-1:0] count_d;

   // Next pending vector: flush, then reserve (newer op wins), then write-clear
   always_comb begin
      pending_d = pending_q;
      count_d   = '0;
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
         if (flush) begin
            pending_d[r] = 1'b0;
         end else if (rsv_valid && (rsv_address == ADDR_WIDTH'(r))) begin
            pending_d[r] = 1'b1;
         end else if ((wr0_valid && (wr0_address == ADDR_WIDTH'(r))) ||
                      (wr1_valid && (wr1_address == ADDR_WIDTH'(r)))) begin
            pending_d[r] = 1'b0;
         end
      end
      pending_d[GPR_ZERO_REG] = 1'b0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         count_d = count_d + CNT_WIDTH'(pending_d[r]);
      end
   end

   // Pending bits and count share the same edge
   always_ff @(posedge clock or negedge reset) begin
      if (reset == RESET_ACTIVE) begin
         pending_q <= '0;
         count_q   <= '0;
      end else begin
         pending_q <= pending_d;
         count_q   <= count_d;
      end
   end

   assign pending_count = count_q;

   // Per-port pending view, masked by a same-cycle writeback to that register
   for (genvar k = 0; k < READ_PORTS; k++) begin : g_pend
      logic [ADDR_WIDTH-1:0] ra;
      logic                  pend_c;

      assign ra = read_address[k*ADDR_WIDTH +: ADDR_WIDTH];

      // Pending unless the register is zero or being written right now
      always_comb begin
         pend_c = pending_q[ra];
         if (ra == ADDR_WIDTH'(GPR_ZERO_REG)) begin
            pend_c = 1'b0;
         end else if ((wr0_valid && (wr0_address == ra)) ||
                      (wr1_valid && (wr1_address == ra))) begin
            pend_c = 1'b0;
         end
      end

      assign read_pending[k] = pend_c;
   end

endmodule

// File: rtl/yutorina_gpr_mp.sv
// Multi-port register file: N bypassed read ports, two prioritised write
// ports (port 1 wins), register 0 hard-wired zero, pending scoreboard.
module yutorina_gpr_mp
   import yutorina_gpr_mp_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = GPR_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = GPR_ADDR_WIDTH,
   parameter int unsigned READ_PORTS = GPR_READ_PORTS
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_address,
   output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
   output logic [READ_PORTS-1:0]            read_pending,
   input  logic                             write_enable0_,
   input  logic [ADDR_WIDTH-1:0]            write_address0,
   input  logic [DATA_WIDTH-1:0]            write_data0,
   input  logic                             write_enable1_,
   input  logic [ADDR_WIDTH-1:0]            write_address1,
   input  logic [DATA_WIDTH-1:0]            write_data1,
   input  logic                             reserve_enable_,
   input  logic [ADDR_WIDTH-1:0]            reserve_address,
   input  logic                             flush_,
   output logic [ADDR_WIDTH:0]              pending_count
);

   localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

   logic wr0_valid;
   logic wr1_valid;
   logic rsv_valid;
   logic flush;

   // Decode strobes; anything aimed at register 0 is dropped here
   always_comb begin
      wr0_valid = strobe_on(write_enable0_) &&
                  (write_address0 != ADDR_WIDTH'(GPR_ZERO_REG));
      wr1_valid = strobe_on(write_enable1_) &&
                  (write_address1 != ADDR_WIDTH'(GPR_ZERO_REG));
      rsv_valid = strobe_on(reserve_enable_) &&
                  (reserve_address != ADDR_WIDTH'(GPR_ZERO_REG));
      flush     = strobe_on(flush_);
   end

   // Next array contents; port 1 applied last so it wins a same-address clash
   always_comb begin
      regs_d = regs_q;
      if (wr0_valid) begin
         regs_d[write_address0] = write_data0;
      end
      if (wr1_valid) begin
         regs_d[write_address1] = write_data1;
      end
   end

   // Storage array
   always_ff @(posedge clock or negedge reset) begin
      if (reset == RESET_ACTIVE) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Read ports with same-cycle writeback bypass
   for (genvar k = 0; k < READ_PORTS; k++) begin : g_read
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] rd_c;

      assign ra = read_address[k*ADDR_WIDTH +: ADDR_WIDTH];

      // Zero register, then port 1 bypass, then port 0 bypass, then array
      always_comb begin
         rd_c = regs_q[ra];
         if (ra == ADDR_WIDTH'(GPR_ZERO_REG)) begin
            rd_c = '0;
         end else if (wr1_valid && (write_address1 == ra)) begin
            rd_c = write_data1;
         end else if (wr0_valid && (write_address0 == ra)) begin
            rd_c = write_data0;
         end
      end

      assign read_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_c;
   end

   yutorina_gpr_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .READ_PORTS (READ_PORTS)
   ) u_scoreboard (
      .clock         (clock),
      .reset         (reset),
      .wr0_valid     (wr0_valid),
      .wr0_address   (write_address0),
      .wr1_valid     (wr1_valid),
      .wr1_address   (write_address1),
      .rsv_valid     (rsv_valid),
      .rsv_address   (reserve_address),
      .flush         (flush),
      .read_address  (read_address),
      .read_pending  (read_pending),
      .pending_count (pending_count)
   );

endmodule

// File: tb/tb_yutorina_gpr_mp.sv
// Self-checking bench for yutorina_gpr_mp against an array-based model.
module tb_yutorina_gpr_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int RP = 2;
   localparam int NR = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic [RP*AW-1:0] read_address;
   logic [RP*DW-1:0] read_data;
   logic [RP-1:0] read_pending;
   logic          write_enable0_;
   logic [AW-1:0] write_address0;
   logic [DW-1:0] write_data0;
   logic          write_enable1_;
   logic [AW-1:0] write_address1;
   logic [DW-1:0] write_data1;
   logic          reserve_enable_;
   logic [AW-1:0] reserve_address;
   logic          flush_;
   logic [AW:0]   pending_count;

   int errors = 0;
   int checks = 0;

   // Reference state
   logic [DW-1:0] m_regs [NR];
   bit            m_pend [NR];
   int            m_count;

   yutorina_gpr_mp dut (
      .clock           (clock),
      .reset           (reset),
      .read_address    (read_address),
      .read_data       (read_data),
      .read_pending    (read_pending),
      .write_enable0_  (write_enable0_),
      .write_address0  (write_address0),
      .write_data0     (write_data0),
      .write_enable1_  (write_enable1_),
      .write_address1  (write_address1),
      .write_data1     (write_data1),
      .reserve_enable_ (reserve_enable_),
      .reserve_address (reserve_address),
      .flush_          (flush_),
      .pending_count   (pending_count)
   );

   always #5 clock = ~clock;

   function automatic void model_clear();
      for (int i = 0; i < NR; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 1'b0;
      end
      m_count = 0;
   endfunction

   // Does the current stimulus write register a on either port?
   function automatic bit writes_to(input logic [AW-1:0] a);
      return (a != 0) && ((!write_enable0_ && write_address0 == a) ||
                          (!write_enable1_ && write_address1 == a));
   endfunction

   function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
      if (a == 0) return '0;
      if (!write_enable1_ && write_address1 == a) return write_data1;
      if (!write_enable0_ && write_address0 == a) return write_data0;
      return m_regs[a];
   endfunction

   function automatic bit exp_pend(input logic [AW-1:0] a);
      return (a != 0) && m_pend[a] && !writes_to(a);
   endfunction

   // Apply the clock-edge rules of the register file to the model
   function automatic void model_edge();
      bit wr_hit [NR];
      for (int r = 0; r < NR; r++) wr_hit[r] = writes_to(AW'(r));
      if (!write_enable0_ && write_address0 != 0) m_regs[write_address0] = write_data0;
      if (!write_enable1_ && write_address1 != 0) m_regs[write_address1] = write_data1;
      for (int r = 1; r < NR; r++) begin
         if (!flush_) m_pend[r] = 1'b0;
         else if (!reserve_enable_ && reserve_address == AW'(r)) m_pend[r] = 1'b1;
         else if (wr_hit[r]) m_pend[r] = 1'b0;
      end
      m_count = 0;
      for (int r = 1; r < NR; r++) m_count += int'(m_pend[r]);
   endfunction

   task automatic set_idle();
      write_enable0_  = 1'b1; write_address0 = '0; write_data0 = '0;
      write_enable1_  = 1'b1; write_address1 = '0; write_data1 = '0;
      reserve_enable_ = 1'b1; reserve_address = '0;
      flush_          = 1'b1;
   endtask

   task automatic set_reads(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      read_address = {a1, a0};
   endtask

   // Advance one clock: model follows the edge, returns at the next falling edge
   task automatic tick();
      model_edge();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic test_reset();
      logic [AW-1:0] a0, a1;
      reset = 1'b0;
      set_idle();
      set_reads('0, '0);
      model_clear();
      repeat (2) @(negedge clock);
      reset = 1'b1;
      for (int a = 0; a < NR; a++) begin
         a0 = AW'(a);
         a1 = AW'(NR - 1 - a);
         set_reads(a0, a1);
         #1;
         checks++;
         if (read_data[0 +: DW] !== 32'h0 || read_data[DW +: DW] !== 32'h0) begin
            errors++;
            $display("FAIL reset_data r%0d: got %h/%h want 0", a, read_data[0 +: DW], read_data[DW +: DW]);
         end
         checks++;
         if (read_pending !== 2'b00) begin
            errors++;
            $display("FAIL reset_pending r%0d: got %b want 00", a, read_pending);
         end
      end
      @(negedge clock);
      checks++;
      if (pending_count !== 6'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d want 0", pending_count);
      end
   endtask

   task automatic test_write_priority();
      write_enable0_ = 1'b0; write_address0 = 5'd5; write_data0 = 32'h11111111;
      write_enable1_ = 1'b0; write_address1 = 5'd5; write_data1 = 32'h22222222;
      set_reads(5'd5, 5'd6);
      #1;
      checks++;
      if (read_data[0 +: DW] !== exp_data(5'd5) || read_data[0 +: DW] !== 32'h22222222) begin
         errors++;
         $display("FAIL prio_bypass: got %h want 22222222", read_data[0 +: DW]);
      end
      tick();
      set_idle();
      #1;
      checks++;
      if (read_data[0 +: DW] !== m_regs[5] || m_regs[5] !== 32'h22222222) begin
         errors++;
         $display("FAIL prio_array: got %h want 22222222", read_data[0 +: DW]);
      end
   endtask

   task automatic test_zero_reg();
      write_enable0_ = 1'b0; write_address0 = 5'd0; write_data0 = 32'hDEADBEEF;
      write_enable1_ = 1'b0; write_address1 = 5'd0; write_data1 = 32'hDEADBEEF;
      set_reads(5'd0, 5'd0);
      #1;
      checks++;
      if (read_data !== 64'h0) begin
         errors++;
         $display("FAIL zero_bypass: got %h want 0", read_data);
      end
      tick();
      set_idle();
      #1;
      checks++;
      if (read_data !== 64'h0) begin
         errors++;
         $display("FAIL zero_after: got %h want 0", read_data);
      end
   endtask

   task automatic test_reserve_write();
      reserve_enable_ = 1'b0; reserve_address = 5'd7;
      set_reads(5'd7, 5'd7);
      #1;
      checks++;
      if (read_pending !== 2'b00) begin
         errors++;
         $display("FAIL rsv_same_cycle: got %b want 00", read_pending);
      end
      tick();
      set_idle();
      #1;
      checks++;
      if (read_pending !== {exp_pend(5'd7), exp_pend(5'd7)} || read_pending !== 2'b11) begin
         errors++;
         $display("FAIL rsv_visible: got %b want 11", read_pending);
      end
      checks++;
      if (pending_count !== 6'(m_count) || m_count != 1) begin
         errors++;
         $display("FAIL rsv_count: got %0d want 1", pending_count);
      end
      write_enable1_ = 1'b0; write_address1 = 5'd7; write_data1 = 32'h1234;
      #1;
      checks++;
      if (read_pending !== 2'b00 || read_data[0 +: DW] !== 32'h1234) begin
         errors++;
         $display("FAIL wb_bypass: got pend=%b data=%h want 00/1234", read_pending, read_data[0 +: DW]);
      end
      tick();
      set_idle();
      checks++;
      if (pending_count !== 6'd0) begin
         errors++;
         $display("FAIL wb_count: got %0d want 0", pending_count);
      end
   endtask

   task automatic test_reserve_vs_write_flush();
      reserve_enable_ = 1'b0; reserve_address = 5'd3;
      write_enable0_ = 1'b0; write_address0 = 5'd3; write_data0 = 32'h55;
      tick();
      set_idle();
      set_reads(5'd3, 5'd3);
      #1;
      checks++;
      if (read_data[0 +: DW] !== 32'h55 || read_pending !== 2'b11 || pending_count !== 6'd1) begin
         errors++;
         $display("FAIL rsv_beats_wr: got data=%h pend=%b cnt=%0d want 55/11/1",
                  read_data[0 +: DW], read_pending, pending_count);
      end
      reserve_enable_ = 1'b0;
      reserve_address = 5'd3; tick();
      reserve_address = 5'd4; tick();
      reserve_address = 5'd9; tick();
      checks++;
      if (pending_count !== 6'(m_count) || m_count != 3) begin
         errors++;
         $display("FAIL multi_rsv_count: got %0d want 3", pending_count);
      end
      flush_ = 1'b0; reserve_address = 5'd10;
      tick();
      set_idle();
      set_reads(5'd10, 5'd9);
      #1;
      checks++;
      if (pending_count !== 6'd0 || read_pending !== 2'b00) begin
         errors++;
         $display("FAIL flush: got cnt=%0d pend=%b want 0/00", pending_count, read_pending);
      end
   endtask

   task automatic test_reset_mid();
      write_enable0_ = 1'b0; write_address0 = 5'd12; write_data0 = 32'h77;
      tick();
      set_idle();
      reserve_enable_ = 1'b0; reserve_address = 5'd12;
      tick();
      set_idle();
      set_reads(5'd12, 5'd12);
      #1;
      checks++;
      if (read_pending !== 2'b11 || pending_count !== 6'd1 || read_data[0 +: DW] !== 32'h77) begin
         errors++;
         $display("FAIL pre_reset: got pend=%b cnt=%0d data=%h want 11/1/77",
                  read_pending, pending_count, read_data[0 +: DW]);
      end
      #1;
      reset = 1'b0;
      model_clear();
      #1;
      checks++;
      if (pending_count !== 6'd0 || read_data !== 64'h0 || read_pending !== 2'b00) begin
         errors++;
         $display("FAIL async_reset: got cnt=%0d data=%h pend=%b want 0/0/00",
                  pending_count, read_data, read_pending);
      end
      @(negedge clock);
      reset = 1'b1;
      write_enable0_ = 1'b0; write_address0 = 5'd12; write_data0 = 32'hA5;
      tick();
      set_idle();
      #1;
      checks++;
      if (read_data[0 +: DW] !== 32'hA5 || read_data[DW +: DW] !== m_regs[12]) begin
         errors++;
         $display("FAIL post_reset_wr: got %h want a5", read_data[0 +: DW]);
      end
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NR - 1));
      return AW'($urandom_range(0, 6));
   endfunction

   task automatic test_random();
      logic [AW-1:0] a0, a1;
      for (int n = 0; n < 400; n++) begin
         write_enable0_  = ($urandom_range(0, 1) == 0);
         write_address0  = rand_addr();
         write_data0     = $urandom;
         write_enable1_  = ($urandom_range(0, 2) != 0);
         write_address1  = rand_addr();
         write_data1     = $urandom;
         reserve_enable_ = ($urandom_range(0, 1) == 0);
         reserve_address = rand_addr();
         flush_          = ($urandom_range(0, 15) != 0);
         a0 = rand_addr();
         a1 = rand_addr();
         set_reads(a0, a1);
         #1;
         checks++;
         if (read_data[0 +: DW] !== exp_data(a0) || read_data[DW +: DW] !== exp_data(a1)) begin
            errors++;
            $display("FAIL rnd_data n=%0d r%0d/r%0d: got %h/%h want %h/%h", n, a0, a1,
                     read_data[0 +: DW], read_data[DW +: DW], exp_data(a0), exp_data(a1));
         end
         checks++;
         if (read_pending !== {exp_pend(a1), exp_pend(a0)}) begin
            errors++;
            $display("FAIL rnd_pend n=%0d r%0d/r%0d: got %b want %b", n, a0, a1,
                     read_pending, {exp_pend(a1), exp_pend(a0)});
         end
         tick();
         checks++;
         if (pending_count !== 6'(m_count)) begin
            errors++;
            $display("FAIL rnd_count n=%0d: got %0d want %0d", n, pending_count, m_count);
         end
      end
      set_idle();
   endtask

   initial begin
      test_reset();
      test_write_priority();
      test_zero_reg();
      test_reserve_write();
      test_reserve_vs_write_flush();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
